instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle fetch stage. Holds PC, OldPC and the instruction register (IR).
//  Fetches one 32-bit word from instruction memory per fetch_start request,
//  using a req/rvalid handshake. Feeds IR[31:7] to the immediate extender and
//  OldPC/PC to the ALU-source muxes. Sequenced by the main control FSM.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset (must be word aligned)
//  TIMEOUT   16             max WAIT cycles for imem_rvalid before fault (>=2)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  fetch_start  in   1   control: begin fetch at current PC (accepted in IDLE only)
//  pc_we        in   1   control: load pc_next into PC (accepted in IDLE only)
//  pc_next      in   32  branch/jump target or ALU result for PC
//  imem_req     out  1   one-cycle read request to instruction memory
//  imem_addr    out  32  read address, equals PC while imem_req=1, else 0
//  imem_rvalid  in   1   memory returns data this cycle
//  imem_rdata   in   32  instruction word, valid when imem_rvalid=1
//  instr        out  32  IR contents
//  inst_ext     out  25  instr[31:7], extender input
//  pc           out  32  current PC
//  old_pc       out  32  PC of the instruction held in IR
//  ir_valid     out  1   IR holds a freshly fetched instruction
//  fetch_busy   out  1   1 in REQ or WAIT
//  fetch_fault  out  1   sticky error: timeout or misaligned pc_next
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; pc=RESET_PC; old_pc=RESET_PC;
//   instr=32'h0000_0013 (NOP); ir_valid=0; fetch_fault=0; imem_req=0; counter=0.
//  States: IDLE, REQ, WAIT, FAULT (2-bit encoded, registered outputs).
//  IDLE:
//   pc_we=1, pc_next[1:0]==0: pc<=pc_next.
//   pc_we=1, pc_next[1:0]!=0: pc unchanged; fetch_fault<=1; ->FAULT.
//   fetch_start=1: ir_valid<=0; ->REQ. Together with a valid pc_we, both
//    occur; the fetch uses the new PC, because REQ drives imem_addr from the register.
//   Misaligned pc_we wins over fetch_start (fetch does not start).
//  REQ: imem_req=1, imem_addr=pc, exactly one cycle; counter<=0; ->WAIT.
//   imem_rvalid in REQ is ignored (memory latency >= 1).
//  WAIT: imem_rvalid=1: instr<=imem_rdata; old_pc<=pc; pc<=pc+4 (mod 2^32,
//    0xFFFF_FFFC wraps to 0); ir_valid<=1; ->IDLE.
//   Otherwise counter<=counter+1. If counter==TIMEOUT-1 with no rvalid:
//    fetch_fault<=1; ->FAULT. rvalid arriving in that last cycle is accepted.
//   Fetch latency = 2 + memory latency (min 3 cycles from fetch_start to ir_valid).
//  FAULT: terminal until reset. imem_req=0. pc, old_pc and instr are frozen.
//   All inputs are ignored.
//  fetch_start/pc_we outside IDLE: ignored (no queueing).
//  imem_rvalid outside WAIT: ignored.
//  ir_valid stays 1 until the next accepted fetch_start.
//  inst_ext is purely combinational from instr.
//  fetch_busy = (state==REQ || state==WAIT).
//  Reset asserted mid-fetch: the fetch is aborted, and a late rvalid after reset is ignored.
// TESTING
//  1 reset, RESET_PC=0 -> pc=0, instr=0x00000013, ir_valid=0, fault=0, req=0.
//  2 fetch_start, rvalid 1 cycle after req with rdata=0x00A00093 ->
//     req pulse 1 cycle at addr 0; instr=0x00A00093; old_pc=0; pc=4;
//     ir_valid=1 on cycle 3 after start; inst_ext=0x0014001.
//  3 pc_we with pc_next=0x100 plus fetch_start in the same cycle ->
//     imem_addr=0x100; after rvalid pc=0x104 and old_pc=0x100.
//  4 pc_we with pc_next=0x102 -> pc unchanged; fetch_fault=1; FAULT;
//     a later fetch_start gives no req; reset clears the fault.
//  5 TIMEOUT=16, no rvalid -> fault is set after the 16th WAIT cycle.
//     Repeat with rvalid on the 16th cycle -> normal capture, no fault.
//  6 pc_next=0xFFFFFFFC then a fetch -> pc wraps to 0. Reset asserted in WAIT,
//     then rvalid -> state IDLE, instr=NOP, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: PC / OldPC / IR with a req/rvalid
// handshake to instruction memory, a bounded wait and a sticky fault state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [24:0] inst_ext,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             misaligned;

    assign misaligned = pc_we && (pc_next[1:0] != 2'b00);

    // Extender input is a plain slice of the instruction register.
    assign inst_ext = instr[31:7];

    // Fetch sequencer; every output is registered alongside the state so
    // imem_req/imem_addr/fetch_busy line up exactly with REQ/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            old_pc      <= RESET_PC;
            instr       <= NOP;
            ir_valid    <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_busy  <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            counter     <= '0;
        end else begin
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        // A bad jump target wins over a concurrent fetch request.
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        if (pc_we) begin
                            pc <= pc_next;
                        end
                        if (fetch_start) begin
                            // Address comes from the PC as it will be in REQ.
                            ir_valid   <= 1'b0;
                            imem_req   <= 1'b1;
                            imem_addr  <= pc_we ? pc_next : pc;
                            fetch_busy <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Memory latency is at least one cycle; rvalid here is ignored.
                    counter <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr      <= imem_rdata;
                        old_pc     <= pc;
                        pc         <= pc + 32'd4;
                        ir_valid   <= 1'b1;
                        fetch_busy <= 1'b0;
                        state      <= IDLE;
                    end else if (counter == LAST_WAIT) begin
                        fetch_fault <= 1'b1;
                        fetch_busy  <= 1'b0;
                        state       <= FAULT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                FAULT: begin
                    // Terminal until reset; architectural state stays frozen.
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected IR/PC
// results, plus directed checks of fault, timeout, wrap and reset abort.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [24:0] inst_ext;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic        ir_valid;
    logic        fetch_busy;
    logic        fetch_fault;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] old_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .inst_ext    (inst_ext),
        .pc          (pc),
        .old_pc      (old_pc),
        .ir_valid    (ir_valid),
        .fetch_busy  (fetch_busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        fetch_start = 1'b0;
        pc_we       = 1'b0;
        pc_next     = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        tick();
        tick();
        reset    = 1'b0;
        model_pc = 32'h0;
    endtask

    // One complete fetch; the memory answers 'lat' cycles after the request.
    task automatic fetch(input logic [31:0] data, input int lat,
                         input bit we, input logic [31:0] nxt);
        logic [31:0] addr;
        exp_t        e;
        addr     = we ? nxt : model_pc;
        e.instr  = data;
        e.old_pc = addr;
        e.pc     = addr + 32'd4;
        sb.push_back(e);

        fetch_start = 1'b1;
        pc_we       = we;
        pc_next     = nxt;
        tick();
        fetch_start = 1'b0;
        pc_we       = 1'b0;
        chk("req_on",   32'(imem_req),   32'd1);
        chk("req_addr", imem_addr,       addr);
        chk("irv_clr",  32'(ir_valid),   32'd0);
        chk("busy_req", 32'(fetch_busy), 32'd1);
        // rvalid during REQ must not be captured
        if (lat >= 2) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        tick();
        imem_rvalid = 1'b0;
        chk("req_pulse", 32'(imem_req), 32'd0);
        chk("addr_zero", imem_addr,     32'h0);
        repeat (lat - 1) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("ir_valid",  32'(ir_valid),   32'd1);
        chk("busy_done", 32'(fetch_busy), 32'd0);
        chk("no_fault",  32'(fetch_fault), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("instr",    instr,  e.instr);
            chk("old_pc",   old_pc, e.old_pc);
            chk("pc",       pc,     e.pc);
            chk("inst_ext", 32'(inst_ext), 32'(e.instr[31:7]));
        end
        model_pc = addr + 32'd4;
    endtask

    initial begin
        do_reset();
        // reset state
        chk("rst_pc",     pc,     32'h0);
        chk("rst_old_pc", old_pc, 32'h0);
        chk("rst_instr",  instr,  NOP);
        chk("rst_irv",    32'(ir_valid),    32'd0);
        chk("rst_fault",  32'(fetch_fault), 32'd0);
        chk("rst_req",    32'(imem_req),    32'd0);
        chk("rst_busy",   32'(fetch_busy),  32'd0);

        // basic fetch at 0, minimum latency
        fetch(32'h00A0_0093, 1, 1'b0, 32'h0);
        chk("ext_const", 32'(inst_ext), 32'h0014001);
        // jump plus fetch in the same cycle
        fetch(32'h0010_0113, 3, 1'b1, 32'h0000_0100);
        fetch(32'h0020_81B3, 2, 1'b0, 32'h0);
        // PC wrap
        fetch(32'h0000_0013, 1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0);
        // rvalid on the last permitted WAIT cycle
        fetch(32'h1234_5678, 16, 1'b0, 32'h0);

        // reset in WAIT, then a late rvalid
        pc_we       = 1'b1;
        pc_next     = 32'h0000_0200;
        fetch_start = 1'b1;
        tick();
        pc_we       = 1'b0;
        fetch_start = 1'b0;
        tick();
        chk("wait_busy", 32'(fetch_busy), 32'd1);
        reset = 1'b1;
        #2;
        chk("async_pc",   pc,    32'h0);
        chk("async_busy", 32'(fetch_busy), 32'd0);
        tick();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        chk("abort_irv",   32'(ir_valid), 32'd0);
        chk("abort_instr", instr, NOP);
        chk("abort_pc",    pc,    32'h0);
        chk("abort_req",   32'(imem_req), 32'd0);
        model_pc = 32'h0;

        // timeout: no rvalid at all
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (16) tick();
        chk("to_nofault", 32'(fetch_fault), 32'd0);
        chk("to_busy",    32'(fetch_busy),  32'd1);
        tick();
        chk("to_fault",   32'(fetch_fault), 32'd1);
        chk("to_busy0",   32'(fetch_busy),  32'd0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("to_noreq", 32'(imem_req), 32'd0);
        chk("to_pc",    pc, 32'h0);

        // misaligned jump beats fetch_start
        do_reset();
        chk("clr_fault", 32'(fetch_fault), 32'd0);
        pc_we       = 1'b1;
        pc_next     = 32'h0000_0102;
        fetch_start = 1'b1;
        tick();
        pc_we       = 1'b0;
        fetch_start = 1'b0;
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_noreq", 32'(imem_req),    32'd0);
        chk("mis_pc",    pc, 32'h0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("mis_noreq2", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0;
        chk("mis_instr", instr, NOP);
        do_reset();
        chk("mis_clr", 32'(fetch_fault), 32'd0);
        fetch(32'h0040_0213, 2, 1'b0, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
